// File: rtl/cpu_mem_arb_pkg.sv
// Shared CPU package: data types, RAM geometry defaults and arbiter state encoding.
// The VERIFY state exists only when CPU_MEM_VERIFY_EN is defined.
package cpu_mem_arb_pkg;

  localparam int unsigned AddrWDefault = 4;
  localparam int unsigned DataWDefault = 8;

  typedef logic [7:0] byte_t;

  typedef enum logic [2:0] {
    StRun,
    StDrain,
    StProg,
`ifdef CPU_MEM_VERIFY_EN
    StVerify,
`endif
    StResume
  } arb_state_e;

endpackage

// File: rtl/cpu_mem_arb.sv
// Arbitrates the program RAM between the CPU and the front-panel loader.
// Define CPU_MEM_VERIFY_EN to read back and check every loader write.
module cpu_mem_arb
  import cpu_mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = AddrWDefault,
  parameter int unsigned DATA_W = DataWDefault
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              prog_mode_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_data_i,
  output logic [DATA_W-1:0] cpu_data_o,
  output logic              cpu_hold_o,
  input  logic              ld_valid_i,
  input  logic [ADDR_W-1:0] ld_addr_i,
  input  logic [DATA_W-1:0] ld_data_i,
  output logic              ld_ready_o,
  output logic [ADDR_W:0]   ld_count_o,
  output logic              ld_err_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_data_o,
  input  logic [DATA_W-1:0] mem_data_i
);

  localparam logic [ADDR_W:0] CountMax = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] CountOne = {{ADDR_W{1'b0}}, 1'b1};

  arb_state_e        state_q, state_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              accept;

`ifdef CPU_MEM_VERIFY_EN
  logic              err_q, err_d;
  logic [ADDR_W-1:0] last_addr_q, last_addr_d;
  logic [DATA_W-1:0] last_data_q, last_data_d;
`endif

  assign cpu_data_o = mem_data_i;
  assign ld_count_o = count_q;

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    cpu_hold_o = 1'b1;
    ld_ready_o = 1'b0;
    mem_we_o   = 1'b0;
    mem_addr_o = cpu_addr_i;
    mem_data_o = cpu_data_i;
    accept     = 1'b0;
`ifdef CPU_MEM_VERIFY_EN
    err_d       = err_q;
    last_addr_d = last_addr_q;
    last_data_d = last_data_q;
`endif
    unique case (state_q)
      StRun: begin
        cpu_hold_o = 1'b0;
        mem_we_o   = cpu_we_i;
        if (prog_mode_i) begin
          state_d = StDrain;
          count_d = '0;
`ifdef CPU_MEM_VERIFY_EN
          err_d   = 1'b0;
`endif
        end
      end
      StDrain: state_d = StProg;
      StProg: begin
        // Ready follows prog_mode_i so a falling request never races a write.
        ld_ready_o = prog_mode_i;
        mem_addr_o = ld_addr_i;
        mem_data_o = ld_data_i;
        accept     = ld_valid_i & prog_mode_i;
        mem_we_o   = accept;
        if (accept && count_q != CountMax) count_d = count_q + CountOne;
        if (!prog_mode_i) begin
          state_d = StResume;
        end
`ifdef CPU_MEM_VERIFY_EN
        else if (accept) begin
          state_d     = StVerify;
          last_addr_d = ld_addr_i;
          last_data_d = ld_data_i;
        end
`endif
      end
`ifdef CPU_MEM_VERIFY_EN
      StVerify: begin
        mem_addr_o = last_addr_q;
        if (mem_data_i != last_data_q) err_d = 1'b1;
        state_d = prog_mode_i ? StProg : StResume;
      end
`endif
      StResume: state_d = StRun;
      default:  state_d = StRun;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StRun;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

`ifdef CPU_MEM_VERIFY_EN
  always_ff @(posedge clk) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= err_d;
  end

  always_ff @(posedge clk) begin
    last_addr_q <= last_addr_d;
    last_data_q <= last_data_d;
  end

  assign ld_err_o = err_q;
`else
  assign ld_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_mem_arb.sv
// Scoreboard bench for cpu_mem_arb: falling-edge RAM model, loader/CPU drivers and a monitor.
module tb_cpu_mem_arb;

  logic       clk = 1'b0;
  logic       reset, prog_mode, cpu_we, ld_valid, fault, cpu_rd;
  logic [3:0] cpu_addr, ld_addr, mem_addr_o;
  logic [7:0] cpu_data, ld_data, cpu_data_o, mem_data_o, mem_data_i, mem_rd;
  logic       cpu_hold_o, ld_ready_o, ld_err_o, mem_we_o;
  logic [4:0] ld_count_o;

  typedef struct {
    logic [3:0] addr;
    logic [7:0] data;
    logic [4:0] cnt;
  } ld_exp_t;

  ld_exp_t    ld_q[$];
  logic [7:0] rd_q[$];
  logic [7:0] ram[16];
  logic [7:0] model_ram[16];
  int         model_cnt;
  logic       model_err;
  int         compared = 0;
  int         mismatched = 0;

  cpu_mem_arb #(.ADDR_W(4), .DATA_W(8)) dut (
    .clk(clk), .reset(reset), .prog_mode_i(prog_mode),
    .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr), .cpu_data_i(cpu_data),
    .cpu_data_o(cpu_data_o), .cpu_hold_o(cpu_hold_o),
    .ld_valid_i(ld_valid), .ld_addr_i(ld_addr), .ld_data_i(ld_data),
    .ld_ready_o(ld_ready_o), .ld_count_o(ld_count_o), .ld_err_o(ld_err_o),
    .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
    .mem_data_i(mem_data_i)
  );

  always #5 clk = ~clk;

  // Read-old RAM on the falling edge; fault forces the read data bus to zero.
  always @(negedge clk) begin
    mem_rd <= ram[mem_addr_o];
    if (mem_we_o) ram[mem_addr_o] <= mem_data_o;
  end
  assign mem_data_i = fault ? 8'h00 : mem_rd;

  function automatic logic [4:0] sat(int n);
    return (n > 16) ? 5'd16 : 5'(n);
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
    #4;
  endtask

  // Monitor: pops expectations whenever a loader write is accepted or a CPU read completes.
  always @(negedge clk) begin
    ld_exp_t    e;
    logic [7:0] r;
    #4;
    if (!reset) begin
      if (ld_valid && ld_ready_o) begin
        if (ld_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL ld_unexpected: got accept addr %0h expected none", ld_addr);
        end else begin
          e = ld_q.pop_front();
          check("ld_we", mem_we_o, 1);
          check("ld_addr", mem_addr_o, e.addr);
          check("ld_data", mem_data_o, e.data);
          check("ld_count", ld_count_o, e.cnt);
        end
      end
      if (cpu_rd && !cpu_hold_o) begin
        if (rd_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL cpu_rd_unexpected: got %0h expected none", cpu_data_o);
        end else begin
          r = rd_q.pop_front();
          check("cpu_rd", cpu_data_o, r);
        end
      end
    end
  end

  task automatic ld_write(logic [3:0] a, logic [7:0] d);
    ld_exp_t e;
    logic    ok;
    ld_valid = 1'b1;
    ld_addr  = a;
    ld_data  = d;
    cpu_we   = 1'($urandom);
    cpu_addr = 4'($urandom);
    cpu_data = 8'($urandom);
    e.addr = a;
    e.data = d;
    e.cnt  = sat(model_cnt);
    ld_q.push_back(e);
    ok = 1'b0;
    for (int i = 0; i < 8 && !ok; i++) begin
      smp();
      ok = ld_ready_o;
      tick();
    end
    if (!ok) begin
      compared++;
      mismatched++;
      $display("FAIL ld_timeout: got no ready expected ready within 8 cycles");
      void'(ld_q.pop_back());
    end else begin
      model_ram[a] = d;
      model_cnt++;
    end
  endtask

  task automatic enter_prog();
    prog_mode = 1'b1;
    cpu_we    = 1'b0;
    tick();
    cpu_we    = 1'b1;
    cpu_addr  = 4'($urandom);
    cpu_data  = 8'($urandom);
    tick();
    model_cnt = 0;
    model_err = 1'b0;
  endtask

  task automatic exit_prog();
    ld_valid  = 1'b0;
    prog_mode = 1'b0;
    tick();
    tick();
    cpu_we = 1'b0;
  endtask

  task automatic cpu_write(logic [3:0] a, logic [7:0] d);
    cpu_we   = 1'b1;
    cpu_addr = a;
    cpu_data = d;
    tick();
    cpu_we = 1'b0;
    model_ram[a] = d;
  endtask

  task automatic cpu_read(logic [3:0] a);
    cpu_addr = a;
    cpu_rd   = 1'b1;
    rd_q.push_back(model_ram[a]);
    tick();
    cpu_rd = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    reset = 1'b1; prog_mode = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_data = '0;
    ld_valid = 1'b0; ld_addr = '0; ld_data = '0; fault = 1'b0; cpu_rd = 1'b0;
    model_cnt = 0; model_err = 1'b0;
    tick(); tick();
    reset = 1'b0;
    smp();
    check("rst_hold", cpu_hold_o, 0);
    check("rst_ready", ld_ready_o, 0);
    check("rst_count", ld_count_o, 0);
    check("rst_err", ld_err_o, 0);
    tick();

    // Handover: CPU write in the same cycle as the program request.
    cpu_we = 1'b1; cpu_addr = 4'd4; cpu_data = 8'h55; prog_mode = 1'b1;
    model_ram[4] = 8'h55;
    smp();
    check("ho_we", mem_we_o, 1);
    check("ho_addr", mem_addr_o, 4);
    check("ho_hold0", cpu_hold_o, 0);
    tick();
    cpu_we = 1'b0;
    smp();
    check("ho_hold1", cpu_hold_o, 1);
    check("ho_drain_ready", ld_ready_o, 0);
    check("ho_drain_we", mem_we_o, 0);
    tick();
    smp();
    check("ho_ready", ld_ready_o, 1);
    tick();
    exit_prog();
    cpu_read(4'd4);

    // Fill and saturation.
    enter_prog();
    for (int a = 0; a < 16; a++) ld_write(4'(a), 8'hF0 + 8'(a));
    ld_valid = 1'b0;
    smp();
    check("fill_count", ld_count_o, 16);
    tick();
    ld_write(4'd0, 8'hAA);
    ld_valid = 1'b0;
    smp();
    check("sat_count", ld_count_o, 16);
    tick();
    exit_prog();
    smp();
    check("fill_run_hold", cpu_hold_o, 0);
    tick();
    cpu_read(4'd3);
    cpu_read(4'd15);
    cpu_read(4'd0);

    // Same-address back-to-back, then exit while a request is pending.
    enter_prog();
    ld_write(4'd6, 8'h01);
    ld_write(4'd6, 8'h02);
    ld_valid = 1'b1; ld_addr = 4'd9; ld_data = ~model_ram[9]; prog_mode = 1'b0; cpu_we = 1'b0;
    smp();
    check("exit_ready", ld_ready_o, 0);
    check("exit_we", mem_we_o, 0);
    tick();
    ld_valid = 1'b0;
    smp();
    check("resume_hold", cpu_hold_o, 1);
    check("resume_we", mem_we_o, 0);
    tick();
    smp();
    check("exit_run_hold", cpu_hold_o, 0);
    tick();
    cpu_read(4'd9);
    cpu_read(4'd6);

    // Reset in the middle of programming.
    enter_prog();
    for (int a = 10; a < 15; a++) ld_write(4'(a), 8'($urandom));
    ld_valid = 1'b0; reset = 1'b1; prog_mode = 1'b0; cpu_we = 1'b0;
    tick();
    reset = 1'b0;
    smp();
    check("prst_hold", cpu_hold_o, 0);
    check("prst_count", ld_count_o, 0);
    check("prst_ready", ld_ready_o, 0);
    check("prst_err", ld_err_o, 0);
    tick();
    for (int a = 10; a < 15; a++) cpu_read(4'(a));

`ifdef CPU_MEM_VERIFY_EN
    // Verify readback against a faulty read bus.
    enter_prog();
    fault = 1'b1;
    ld_write(4'd2, 8'h3C);
    ld_valid = 1'b0;
    smp();
    check("ver_ready", ld_ready_o, 0);
    tick();
    fault = 1'b0;
    smp();
    check("ver_err", ld_err_o, 1);
    check("ver_ready_back", ld_ready_o, 1);
    tick();
    ld_write(4'd5, 8'h77);
    exit_prog();
    smp();
    check("ver_err_sticky", ld_err_o, 1);
    tick();
    prog_mode = 1'b1;
    tick();
    smp();
    check("ver_err_drain", ld_err_o, 0);
    tick();
    model_cnt = 0;
    model_err = 1'b0;
    exit_prog();
    cpu_read(4'd2);
    cpu_read(4'd5);
`endif

    // Randomized sessions.
    for (int s = 0; s < 6; s++) begin
      enter_prog();
      for (int n = $urandom_range(1, 20); n > 0; n--) begin
        ld_write(4'($urandom), 8'($urandom));
        if ($urandom_range(0, 3) == 0) begin
          ld_valid = 1'b0;
          tick();
        end
      end
      ld_valid = 1'b0;
      smp();
      check("rnd_count", ld_count_o, sat(model_cnt));
      check("rnd_err", ld_err_o, model_err);
      tick();
      exit_prog();
      for (int k = 0; k < 8; k++) begin
        if ($urandom_range(0, 1) == 1) cpu_write(4'($urandom), 8'($urandom));
        else cpu_read(4'($urandom));
      end
    end

    for (int a = 0; a < 16; a++) cpu_read(4'(a));
    tick(); tick();
    check("ld_q_empty", ld_q.size(), 0);
    check("rd_q_empty", rd_q.size(), 0);
    d = 8'h00;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
